count_7seg_display: RTL and testbench
=====================================

COUNT_7SEG_DISPLAY -- requirements
Module: count_7seg_display

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot (1 kHz digit rate at 100 MHz).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all flops on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port count, input, 12 bits: unsigned binary value from the up counter, synchronous to clk.
REQ-005 The block SHALL have port bcd, output, 16 bits: {thousands, hundreds, tens, ones} of the last completed conversion.
REQ-006 The block SHALL have port bcd_valid, output, 1 bit: one-cycle pulse when bcd updates.
REQ-007 The block SHALL have port seg, output, 7 bits: {g,f,e,d,c,b,a}, active-low.
REQ-008 The block SHALL have port an, output, 4 bits: digit anodes, active-low; an[0] is the ones digit.

Function
REQ-009 The conversion FSM SHALL have states IDLE, CONVERT, DONE; reset state IDLE.
REQ-010 In IDLE the FSM SHALL capture count into a 12-bit shift register, clear a 16-bit BCD accumulator, clear the iteration counter, and go to CONVERT.
REQ-011 In CONVERT each cycle SHALL add 3 to every BCD nibble >= 5, then shift {bcd, shift} left by 1 (double-dabble); after exactly 12 iterations it SHALL go to DONE.
REQ-012 In DONE the FSM SHALL load bcd from the accumulator, assert bcd_valid for that cycle only, and return to IDLE.
REQ-013 The conversion period SHALL be exactly 14 cycles (1 IDLE + 12 CONVERT + 1 DONE), repeating continuously.
REQ-014 Latency from count capture in IDLE to bcd/bcd_valid SHALL be 13 cycles.
REQ-015 Changes on count during CONVERT or DONE SHALL NOT affect the conversion in progress; the next IDLE samples the new value.
REQ-016 For all count in 0..4095 bcd SHALL equal the exact decimal value, with no nibble exceeding 9.
REQ-017 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap a 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-018 seg and an SHALL be registered: one cycle after index i is present, an SHALL equal ~(1<<i) and seg SHALL show nibble i of bcd.
REQ-019 Leading zeros SHALL be displayed (4095 shows 4,0,9,5; 7 shows 0,0,0,7).
REQ-020 Segment patterns SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any nibble >9 SHALL produce 1111111.
REQ-021 bcd updating while a digit is lit SHALL change seg on the next cycle without disturbing an or the refresh timing.

Reset
REQ-022 While rst_n=0 the block SHALL force FSM=IDLE, bcd=16'h0000, bcd_valid=0, refresh counter=0, digit index=0, seg=7'b1111111, an=4'b1111.
REQ-023 Reset asserted mid-conversion SHALL abandon the conversion; the first capture SHALL occur in the first cycle after release.
REQ-024 In the first cycle after release, an SHALL become 4'b1110 and seg 7'b1000000.

Structure
REQ-025 A shared package SHALL hold the FSM state enum, the 14-cycle/12-iteration constants, and the ten segment patterns plus blank.
REQ-026 Segment decoding SHALL be a combinational sub-module seg7_decode (4-bit nibble in, 7-bit active-low seg out); conversion, refresh and output registers stay in count_7seg_display.

Verification
REQ-027 Reset, count=0 held -> bcd_valid first pulses 13 cycles after release, bcd=16'h0000, all four digits show 1000000.
REQ-028 count=4095, REFRESH_DIV=4 -> bcd=16'h4095; an walks 1110,1101,1011,0111 every 4 cycles with seg 0010010, 0010000, 1000000, 0011001.
REQ-029 count=1234 captured, changed to 0999 on the third CONVERT cycle -> that conversion gives 16'h1234, the next gives 16'h0999, bcd_valid pulses 14 cycles apart.
REQ-030 rst_n dropped on the sixth CONVERT cycle with bcd=16'h4095 -> seg=1111111, an=1111, bcd=0 immediately; after release the first bcd_valid follows 13 cycles later.
REQ-031 Sweep count 0..4095 from a free-running up counter, checking each bcd_valid -> bcd matches the decimal of the captured value, no nibble >9, no blank pattern seen.

Source files
------------

// File: rtl/count_7seg_display_pkg.sv
// Shared definitions for the count-to-7-segment display block.
// Holds the conversion FSM states, the conversion timing constants,
// the segment patterns and the double-dabble nibble adjust helper.
package count_7seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } conv_state_e;

  // One IDLE cycle, one DONE cycle and one CONVERT cycle per input bit.
  localparam int CONV_PERIOD = 14;
  localparam int CONV_ITERS  = CONV_PERIOD - 2;

  // Segment patterns, {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] value);
    logic [15:0] result;
    result = value;
    for (int i = 0; i < 4; i++) begin
      if (value[4*i +: 4] >= 4'd5) begin
        result[4*i +: 4] = value[4*i +: 4] + 4'd3;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/count_7seg_display_seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Any nibble outside 0..9 blanks the digit.
module seg7_decode
  import count_7seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Look up the segment pattern for the nibble, blank by default.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_7seg_display.sv
// Converts a 12-bit count to four BCD digits with a continuously
// repeating double-dabble FSM, and scans the digits onto a multiplexed
// active-low 7-segment display with registered seg/an outputs.
module count_7seg_display
  import count_7seg_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] count,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int REFRESH_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  conv_state_e          state_q, state_d;
  logic [11:0]          shift_q, shift_d;
  logic [15:0]          acc_q, acc_d;
  logic [3:0]           iter_q, iter_d;
  logic [15:0]          bcd_q, bcd_d;
  logic                 bcd_valid_q, bcd_valid_d;
  logic [REFRESH_W-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]           digit_idx_q, digit_idx_d;
  logic [6:0]           seg_q, seg_d;
  logic [3:0]           an_q, an_d;
  logic [27:0]          dabble_shifted;
  logic [3:0]           digit_nibble;
  logic [6:0]           digit_seg;

  // Next-state logic for the capture / double-dabble / publish cycle.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    acc_d          = acc_q;
    iter_d         = iter_q;
    bcd_d          = bcd_q;
    bcd_valid_d    = 1'b0;
    dabble_shifted = '0;
    case (state_q)
      IDLE: begin
        shift_d = count;
        acc_d   = '0;
        iter_d  = '0;
        state_d = CONVERT;
      end
      CONVERT: begin
        dabble_shifted = {dabble_adjust(acc_q), shift_q} << 1;
        acc_d          = dabble_shifted[27:12];
        shift_d        = dabble_shifted[11:0];
        iter_d         = iter_q + 4'd1;
        if (iter_q == 4'(CONV_ITERS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d       = acc_q;
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Conversion FSM registers, including the published bcd and its pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      acc_q       <= '0;
      iter_q      <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      iter_q      <= iter_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  // Pick the nibble of the digit currently being scanned.
  always_comb begin
    digit_nibble = bcd_q[3:0];
    case (digit_idx_q)
      2'd0: digit_nibble = bcd_q[3:0];
      2'd1: digit_nibble = bcd_q[7:4];
      2'd2: digit_nibble = bcd_q[11:8];
      2'd3: digit_nibble = bcd_q[15:12];
      default: digit_nibble = bcd_q[3:0];
    endcase
  end

  seg7_decode u_seg7_decode (
    .nibble (digit_nibble),
    .seg    (digit_seg)
  );

  // Refresh timing and next values for the digit index and display outputs.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + 1'b1;
    digit_idx_d   = digit_idx_q;
    if (refresh_cnt_q == REFRESH_W'(REFRESH_DIV - 1)) begin
      refresh_cnt_d = '0;
      digit_idx_d   = digit_idx_q + 2'd1;
    end
    an_d  = ~(4'b0001 << digit_idx_q);
    seg_d = digit_seg;
  end

  // Display scan registers; reset blanks the display with all anodes off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt_q <= '0;
      digit_idx_q   <= '0;
      seg_q         <= SEG_BLANK;
      an_q          <= 4'b1111;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      digit_idx_q   <= digit_idx_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign seg       = seg_q;
  assign an        = an_q;

endmodule

// File: tb/tb_count_7seg_display.sv
// Self-checking bench for count_7seg_display with a fast refresh divider.
module tb_count_7seg_display;

  localparam int TB_DIV = 4;

  logic        clk;
  logic        rst_n;
  logic [11:0] count;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks;
  int errors;
  int edge_cnt;

  logic [6:0] ref_seg [0:9];

  typedef struct {
    logic [11:0] cnt;
    logic [15:0] exp_bcd;
  } vec_t;

  vec_t vecs [0:11];

  count_7seg_display #(.REFRESH_DIV(TB_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .count     (count),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .seg       (seg),
    .an        (an)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the stimulus.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time exhausted, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  // Decimal digits of a value computed with plain arithmetic.
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Digit lit after the k-th rising edge since reset release.
  function automatic int scan_idx(input int k);
    return ((k - 1) / TB_DIV) % 4;
  endfunction

  function automatic logic [3:0] exp_an(input int k);
    logic [3:0] onehot;
    onehot = 4'b0001 << scan_idx(k);
    return ~onehot;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k);
    int nib;
    nib = int'((v >> (4 * scan_idx(k))) & 16'h000F);
    return (nib <= 9) ? ref_seg[nib] : 7'b1111111;
  endfunction

  function automatic bit nibbles_ok(input logic [15:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, edge_cnt);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] value);
    count = value;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic wait_valid(input int max_cycles, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bcd_valid && n < max_cycles);
    if (!bcd_valid) checkOutput("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    edge_cnt = 0;
  endtask

  task automatic check_disp(input string name, input logic [15:0] shown);
    checkOutput({name, "_an"}, 32'(an), 32'(exp_an(edge_cnt)));
    checkOutput({name, "_seg"}, 32'(seg), 32'(exp_seg(shown, edge_cnt)));
  endtask

  initial begin
    int n;
    logic [11:0] q [$];
    logic [15:0] model_bcd;
    logic [15:0] disp_bcd;
    logic        exp_valid;

    checks   = 0;
    errors   = 0;
    edge_cnt = 0;
    ref_seg[0] = 7'b1000000; ref_seg[1] = 7'b1111001; ref_seg[2] = 7'b0100100;
    ref_seg[3] = 7'b0110000; ref_seg[4] = 7'b0011001; ref_seg[5] = 7'b0010010;
    ref_seg[6] = 7'b0000010; ref_seg[7] = 7'b1111000; ref_seg[8] = 7'b0000000;
    ref_seg[9] = 7'b0010000;
    vecs[0]  = '{12'd0,    16'h0000};
    vecs[1]  = '{12'd7,    16'h0007};
    vecs[2]  = '{12'd9,    16'h0009};
    vecs[3]  = '{12'd10,   16'h0010};
    vecs[4]  = '{12'd99,   16'h0099};
    vecs[5]  = '{12'd100,  16'h0100};
    vecs[6]  = '{12'd505,  16'h0505};
    vecs[7]  = '{12'd999,  16'h0999};
    vecs[8]  = '{12'd1000, 16'h1000};
    vecs[9]  = '{12'd2048, 16'h2048};
    vecs[10] = '{12'd3579, 16'h3579};
    vecs[11] = '{12'd4095, 16'h4095};

    // Reset values, then first pulse with count held at zero.
    rst_n = 1'b0;
    applyStimulus(12'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_seg", 32'(seg), 32'h7F);
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_bcd", 32'(bcd), 32'h0);
    checkOutput("rst_valid", 32'(bcd_valid), 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    edge_cnt = 0;
    tick();
    checkOutput("rel_an", 32'(an), 32'hE);
    checkOutput("rel_seg", 32'(seg), 32'h40);
    wait_valid(40, n);
    // capture in the first cycle, then 13 cycles of latency
    checkOutput("zero_latency", 32'(n), 32'd13);
    checkOutput("zero_bcd", 32'(bcd), 32'h0000);
    for (int i = 0; i < 16; i++) begin
      tick();
      check_disp("zero_disp", 16'h0000);
    end

    // 4095 shown on a fast scan.
    applyStimulus(12'd4095);
    do_reset();
    wait_valid(40, n);
    checkOutput("max_latency", 32'(n), 32'd14);
    checkOutput("max_bcd", 32'(bcd), 32'h4095);
    for (int i = 0; i < 16; i++) begin
      tick();
      check_disp("max_disp", 16'h4095);
    end

    // Table of fixed values; the second pulse after a change is the new value.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].cnt);
      wait_valid(30, n);
      wait_valid(30, n);
      checkOutput($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].exp_bcd));
      checkOutput($sformatf("vec%0d_nib", i), 32'(nibbles_ok(bcd)), 32'd1);
    end

    // Count changes on the third CONVERT cycle must not disturb the conversion.
    applyStimulus(12'd1234);
    repeat (3) tick();
    applyStimulus(12'd999);
    wait_valid(30, n);
    checkOutput("chg_latency", 32'(n), 32'd11);
    checkOutput("chg_bcd_old", 32'(bcd), 32'h1234);
    wait_valid(30, n);
    checkOutput("chg_period", 32'(n), 32'd14);
    checkOutput("chg_bcd_new", 32'(bcd), 32'h0999);
    tick();
    check_disp("chg_disp", 16'h0999);
    checkOutput("chg_pulse_len", 32'(bcd_valid), 32'd0);

    // Reset in the middle of a conversion.
    applyStimulus(12'd4095);
    wait_valid(30, n);
    wait_valid(30, n);
    checkOutput("mid_pre_bcd", 32'(bcd), 32'h4095);
    tick();
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_seg", 32'(seg), 32'h7F);
    checkOutput("mid_an", 32'(an), 32'hF);
    checkOutput("mid_bcd", 32'(bcd), 32'h0);
    checkOutput("mid_valid", 32'(bcd_valid), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    edge_cnt = 0;
    wait_valid(40, n);
    checkOutput("mid_latency", 32'(n), 32'd14);
    checkOutput("mid_bcd_after", 32'(bcd), 32'h4095);

    // Up-counter sweep followed by random counts, against the model.
    applyStimulus(12'd0);
    do_reset();
    model_bcd = 16'h0000;
    for (int i = 0; i < 4096 + 1400; i++) begin
      if (edge_cnt % 14 == 0) q.push_back(count);
      disp_bcd = model_bcd;
      tick();
      exp_valid = (edge_cnt % 14 == 0);
      if (exp_valid && q.size() > 0) model_bcd = to_bcd(int'(q.pop_front()));
      checkOutput("sweep_valid", 32'(bcd_valid), 32'(exp_valid));
      if (bcd_valid) begin
        checkOutput("sweep_bcd", 32'(bcd), 32'(model_bcd));
        checkOutput("sweep_nib", 32'(nibbles_ok(bcd)), 32'd1);
      end
      check_disp("sweep_disp", disp_bcd);
      if (i + 1 < 4096) applyStimulus(12'(i + 1));
      else applyStimulus(12'($urandom_range(0, 4095)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
